mem_wb_multi: RTL and testbench

- Parametrised successor to the single-lane MEM→WB pipeline register.
- Latches LANES parallel write-back bundles (GPR write plus HI/LO write) from the MEM stage on the rising clock edge.
- Applies the core stall/flush protocol: advance, hold, bubble insertion, flush.
- Resolves intra-bundle write conflicts and owns the multi-cycle MEM wait counter that the MEM-stage DFA reads back.

---
 rtl/mem_wb_multi_pkg.sv | 27 ++
 rtl/mem_wb_multi_if.sv | 16 +
 rtl/mem_wb_multi_lane.sv | 59 +++++
 rtl/mem_wb_multi.sv | 115 +++++++++++
 tb/tb_mem_wb_multi.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_multi_pkg.sv
// Shared constants and stage-mode decode for the multi-lane MEM->WB register.
package mem_wb_multi_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;
  localparam logic        WriteDisable = 1'b0;
  localparam int unsigned ZeroWord     = 0;
  localparam int unsigned NOPRegAddr   = 0;

  typedef enum logic [1:0] {
    MODE_CLEAR,
    MODE_BUBBLE,
    MODE_ADVANCE,
    MODE_HOLD
  } wb_mode_e;

  // rst is handled separately by each register; this covers flush > bubble > advance > hold
  function automatic wb_mode_e decode_mode(input logic flush, input logic stop_here,
                                           input logic stop_down);
    if (flush)                                         return MODE_CLEAR;
    else if (stop_here == Stop && stop_down == NoStop) return MODE_BUBBLE;
    else if (stop_here == NoStop)                      return MODE_ADVANCE;
    else                                               return MODE_HOLD;
  endfunction

endpackage

// File: rtl/mem_wb_multi_if.sv
// Write-back bundle bus: LANES packed lanes of GPR and HI/LO write fields.
interface mem_wb_multi_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [LANES*ADDR_W-1:0] wd;
  logic [LANES-1:0]        wreg;
  logic [LANES*DATA_W-1:0] wdata;
  logic [LANES-1:0]        whilo;
  logic [LANES*DATA_W-1:0] hi;
  logic [LANES*DATA_W-1:0] lo;

  modport master (output wd, wreg, wdata, whilo, hi, lo);
  modport slave  (input  wd, wreg, wdata, whilo, hi, lo);
endinterface

// File: rtl/mem_wb_multi_lane.sv
// One write-back lane register with its own clear/capture/hold priority mux.
module mem_wb_lane
  import mem_wb_multi_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  wb_mode_e          i_mode,
  input  logic [ADDR_W-1:0] i_wd,
  input  logic              i_wreg,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_whilo,
  input  logic [DATA_W-1:0] i_hi,
  input  logic [DATA_W-1:0] i_lo,
  input  logic              i_kill_wreg,
  input  logic              i_kill_whilo,
  output logic [ADDR_W-1:0] o_wd,
  output logic              o_wreg,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_whilo,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  logic [ADDR_W-1:0] r_wd;
  logic              r_wreg;
  logic [DATA_W-1:0] r_wdata;
  logic              r_whilo;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  always_ff @(posedge clk) begin
    if (rst == RstEnable || i_mode == MODE_CLEAR || i_mode == MODE_BUBBLE) begin
      r_wd    <= ADDR_W'(NOPRegAddr);
      r_wreg  <= WriteDisable;
      r_wdata <= DATA_W'(ZeroWord);
      r_whilo <= WriteDisable;
      r_hi    <= DATA_W'(ZeroWord);
      r_lo    <= DATA_W'(ZeroWord);
    end else if (i_mode == MODE_ADVANCE) begin
      r_wd    <= i_wd;
      r_wreg  <= i_wreg & ~i_kill_wreg;
      r_wdata <= i_wdata;
      r_whilo <= i_whilo & ~i_kill_whilo;
      r_hi    <= i_hi;
      r_lo    <= i_lo;
    end
  end

  assign o_wd    = r_wd;
  assign o_wreg  = r_wreg;
  assign o_wdata = r_wdata;
  assign o_whilo = r_whilo;
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

endmodule

// File: rtl/mem_wb_multi.sv
// Multi-lane MEM->WB pipeline register with conflict resolution and MEM wait counter.
// Optional perf counters (perf_bubble, perf_kill) enabled by defining MEM_WB_PERF_EN.
module mem_wb_multi
  import mem_wb_multi_pkg::*;
#(
  parameter int unsigned LANES   = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned STAGE   = 4,
  parameter int unsigned CNT_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  mem_wb_multi_if.slave      i_mem,
  mem_wb_multi_if.master     o_wb,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               cnt_sat
`ifdef MEM_WB_PERF_EN
  ,
  output logic [31:0]        perf_bubble,
  output logic [31:0]        perf_kill
`endif
);

  wb_mode_e         w_mode;
  logic [LANES-1:0] w_kill_wreg;
  logic [LANES-1:0] w_kill_whilo;
  logic [CNT_W-1:0] r_cnt;

  assign w_mode = decode_mode(flush, stall[STAGE], stall[STAGE+1]);

  // Younger lanes win: an older lane's enable is dropped if any younger lane writes the same target.
  always_comb begin
    w_kill_wreg  = '0;
    w_kill_whilo = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i_mem.wd[i*ADDR_W +: ADDR_W] == ADDR_W'(NOPRegAddr)) w_kill_wreg[i] = 1'b1;
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (i_mem.wreg[j] && i_mem.wd[j*ADDR_W +: ADDR_W] == i_mem.wd[i*ADDR_W +: ADDR_W])
          w_kill_wreg[i] = 1'b1;
        if (i_mem.whilo[j]) w_kill_whilo[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_cnt <= '0;
    end else begin
      case (w_mode)
        MODE_CLEAR, MODE_ADVANCE: r_cnt <= '0;
        MODE_BUBBLE:              if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        default:                  r_cnt <= r_cnt;
      endcase
    end
  end

  assign cnt_o   = r_cnt;
  assign cnt_sat = &r_cnt;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mem_wb_lane #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .i_mode       (w_mode),
      .i_wd         (i_mem.wd[g*ADDR_W +: ADDR_W]),
      .i_wreg       (i_mem.wreg[g]),
      .i_wdata      (i_mem.wdata[g*DATA_W +: DATA_W]),
      .i_whilo      (i_mem.whilo[g]),
      .i_hi         (i_mem.hi[g*DATA_W +: DATA_W]),
      .i_lo         (i_mem.lo[g*DATA_W +: DATA_W]),
      .i_kill_wreg  (w_kill_wreg[g]),
      .i_kill_whilo (w_kill_whilo[g]),
      .o_wd         (o_wb.wd[g*ADDR_W +: ADDR_W]),
      .o_wreg       (o_wb.wreg[g]),
      .o_wdata      (o_wb.wdata[g*DATA_W +: DATA_W]),
      .o_whilo      (o_wb.whilo[g]),
      .o_hi         (o_wb.hi[g*DATA_W +: DATA_W]),
      .o_lo         (o_wb.lo[g*DATA_W +: DATA_W])
    );
  end

`ifdef MEM_WB_PERF_EN
  logic [31:0] r_perf_bubble;
  logic [31:0] r_perf_kill;
  logic [31:0] w_kill_cnt;

  always_comb begin
    w_kill_cnt = '0;
    for (int unsigned i = 0; i < LANES; i++)
      if ((i_mem.wreg[i] && w_kill_wreg[i]) || (i_mem.whilo[i] && w_kill_whilo[i]))
        w_kill_cnt = w_kill_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_perf_bubble <= '0;
      r_perf_kill   <= '0;
    end else begin
      if (w_mode == MODE_BUBBLE)  r_perf_bubble <= r_perf_bubble + 32'd1;
      if (w_mode == MODE_ADVANCE) r_perf_kill   <= r_perf_kill + w_kill_cnt;
    end
  end

  assign perf_bubble = r_perf_bubble;
  assign perf_kill   = r_perf_kill;
`endif

endmodule

// File: tb/tb_mem_wb_multi.sv
// Scoreboard bench for mem_wb_multi (2 lanes); perf counters checked when MEM_WB_PERF_EN is defined.
module tb_mem_wb_multi;
  localparam int unsigned LANES   = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned STALL_W = 6;
  localparam int unsigned CNT_W   = 2;

  typedef struct {
    logic [LANES*ADDR_W-1:0] wd;
    logic [LANES-1:0]        wreg;
    logic [LANES*DATA_W-1:0] wdata;
    logic [LANES-1:0]        whilo;
    logic [LANES*DATA_W-1:0] hi;
    logic [LANES*DATA_W-1:0] lo;
    logic [CNT_W-1:0]        cnt;
    logic [31:0]             pb;
    logic [31:0]             pk;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [CNT_W-1:0]   cnt_o;
  logic               cnt_sat;
`ifdef MEM_WB_PERF_EN
  logic [31:0]        perf_bubble;
  logic [31:0]        perf_kill;
`endif

  mem_wb_multi_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem ();
  mem_wb_multi_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wb ();

  mem_wb_multi #(
    .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .STALL_W(STALL_W), .STAGE(4), .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .flush   (flush),
    .i_mem   (u_mem),
    .o_wb    (u_wb),
    .cnt_o   (cnt_o),
    .cnt_sat (cnt_sat)
`ifdef MEM_WB_PERF_EN
    ,
    .perf_bubble (perf_bubble),
    .perf_kill   (perf_kill)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  exp_t        sb_q[$];
  exp_t        m;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic set_lane(input int unsigned l, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input logic whilo,
                          input logic [31:0] hi, input logic [31:0] lo);
    u_mem.wd[l*ADDR_W +: ADDR_W]    = wd;
    u_mem.wreg[l]                   = wreg;
    u_mem.wdata[l*DATA_W +: DATA_W] = wdata;
    u_mem.whilo[l]                  = whilo;
    u_mem.hi[l*DATA_W +: DATA_W]    = hi;
    u_mem.lo[l*DATA_W +: DATA_W]    = lo;
  endtask

  task automatic rand_lanes(input int unsigned wd_max);
    for (int l = 0; l < LANES; l++)
      set_lane(l, 5'($urandom_range(wd_max, 0)), 1'($urandom), $urandom, 1'($urandom),
               $urandom, $urandom);
  endtask

  function automatic void clear_fields();
    m.wd = '0; m.wreg = '0; m.wdata = '0; m.whilo = '0; m.hi = '0; m.lo = '0;
  endfunction

  // Model: scan youngest to oldest, remembering which targets are already claimed.
  task automatic step();
    exp_t        e;
    logic [31:0] claimed;
    logic        hilo_claimed;
    logic [4:0]  wd;
    if (rst) begin
      clear_fields(); m.cnt = 0; m.pb = 0; m.pk = 0;
    end else if (flush) begin
      clear_fields(); m.cnt = 0;
    end else if (stall[4] && !stall[5]) begin
      clear_fields();
      if (m.cnt != 2'd3) m.cnt = m.cnt + 2'd1;
      m.pb = m.pb + 1;
    end else if (!stall[4]) begin
      claimed = '0;
      hilo_claimed = 1'b0;
      m.wd = u_mem.wd; m.wdata = u_mem.wdata; m.hi = u_mem.hi; m.lo = u_mem.lo;
      for (int l = LANES - 1; l >= 0; l--) begin
        wd = u_mem.wd[l*ADDR_W +: ADDR_W];
        m.wreg[l]  = u_mem.wreg[l] && wd != 0 && !claimed[wd];
        m.whilo[l] = u_mem.whilo[l] && !hilo_claimed;
        if (u_mem.wreg[l]) claimed[wd] = 1'b1;
        if (u_mem.whilo[l]) hilo_claimed = 1'b1;
        if ((u_mem.wreg[l] && !m.wreg[l]) || (u_mem.whilo[l] && !m.whilo[l])) m.pk = m.pk + 1;
      end
      m.cnt = 0;
    end
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("wd",      128'(u_wb.wd),    128'(e.wd));
    chk("wreg",    128'(u_wb.wreg),  128'(e.wreg));
    chk("wdata",   128'(u_wb.wdata), 128'(e.wdata));
    chk("whilo",   128'(u_wb.whilo), 128'(e.whilo));
    chk("hi",      128'(u_wb.hi),    128'(e.hi));
    chk("lo",      128'(u_wb.lo),    128'(e.lo));
    chk("cnt_o",   128'(cnt_o),      128'(e.cnt));
    chk("cnt_sat", 128'(cnt_sat),    128'(e.cnt == 2'd3));
`ifdef MEM_WB_PERF_EN
    chk("perf_bubble", 128'(perf_bubble), 128'(e.pb));
    chk("perf_kill",   128'(perf_kill),   128'(e.pk));
`endif
  endtask

  logic [STALL_W-1:0] stall_tbl [4] = '{6'b000000, 6'b011111, 6'b111111, 6'b001111};

  initial begin
    m = '{default: '0};
    rst = 1'b1; flush = 1'b0; stall = $urandom;
    rand_lanes(31);
    step();
    rand_lanes(31); stall = $urandom; flush = 1'($urandom);
    step();

    rst = 1'b0; flush = 1'b0; stall = '0;
    set_lane(0, 5'd3, 1'b1, 32'hAAAA0001, 1'b0, 32'h1, 32'h2);
    set_lane(1, 5'd7, 1'b1, 32'hBBBB0002, 1'b0, 32'h3, 32'h4);
    step();

    set_lane(0, 5'd9, 1'b1, 32'h11111111, 1'b1, 32'hA0, 32'hB0);
    set_lane(1, 5'd9, 1'b1, 32'h22222222, 1'b1, 32'hA1, 32'hB1);
    step();
    set_lane(0, 5'd0, 1'b1, 32'h33333333, 1'b0, 32'h0, 32'h0);
    set_lane(1, 5'd4, 1'b1, 32'h44444444, 1'b0, 32'h0, 32'h0);
    step();

    stall = 6'b011111;
    for (int k = 0; k < 5; k++) begin
      rand_lanes(31);
      step();
    end
    stall = '0;
    set_lane(0, 5'd12, 1'b1, 32'hCAFE0000, 1'b1, 32'h5, 32'h6);
    set_lane(1, 5'd13, 1'b1, 32'hCAFE0001, 1'b0, 32'h7, 32'h8);
    step();

    set_lane(0, 5'd5, 1'b1, 32'h12345678, 1'b0, 32'h9, 32'hA);
    set_lane(1, 5'd6, 1'b1, 32'h9ABCDEF0, 1'b1, 32'hB, 32'hC);
    step();
    stall = 6'b111111;
    for (int k = 0; k < 3; k++) begin
      rand_lanes(31);
      step();
    end

    stall = 6'b011111;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;

    for (int k = 0; k < 60; k++) begin
      rand_lanes(3);
      stall = stall_tbl[$urandom_range(3, 0)];
      flush = ($urandom_range(7, 0) == 0);
      rst   = ($urandom_range(19, 0) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
